// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, FSM state codes and GF(2^8) S-box helper.
// The S-box is computed (inverse plus affine map) instead of tabulated.
package aes_pkg;

    localparam int unsigned NumRounds = 10;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef logic [1:0] ks_state_t;
    localparam ks_state_t StIdle = 2'd0;
    localparam ks_state_t StEmit = 2'd1;
    localparam ks_state_t StDone = 2'd2;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        // x^254 is the multiplicative inverse; 0 maps to 0 naturally.
        for (int i = 7; i >= 0; i--) begin
            inv = gf_mul(inv, inv);
            if (i != 0) inv = gf_mul(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/key_sched_ctrl_if.sv
// Round-key stream interface for key_sched_ctrl.
// KS_CACHE_EN adds the rd_idx/rd_key readout port pair.
interface key_sched_ctrl_if;
    import aes_pkg::*;

    logic       start;
    block_t     key;
    logic       abort;
    logic       rk_ready;
    logic       rk_valid;
    block_t     rk;
    logic [3:0] rk_idx;
    logic       busy;
    logic       done;
`ifdef KS_CACHE_EN
    logic [3:0] rd_idx;
    block_t     rd_key;
`endif

    modport master (
        output start, key, abort, rk_ready,
`ifdef KS_CACHE_EN
        output rd_idx,
        input  rd_key,
`endif
        input  rk_valid, rk, rk_idx, busy, done
    );

    modport slave (
        input  start, key, abort, rk_ready,
`ifdef KS_CACHE_EN
        input  rd_idx,
        output rd_key,
`endif
        output rk_valid, rk, rk_idx, busy, done
    );

endinterface

// File: rtl/aes_sbox.sv
// Single-byte AES forward S-box.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = sbox(a);

endmodule

// File: rtl/key_round_step.sv
// Combinational AES-128 key expansion step: next round key from key k and round r.
module key_round_step
    import aes_pkg::*;
(
    input  block_t     k,
    input  logic [3:0] r,
    output block_t     nk
);

    word_t w0, w1, w2, w3;
    word_t rot, sub, rc, t;
    word_t n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = k;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .a (rot[8*b +: 8]),
            .y (sub[8*b +: 8])
        );
    end

    rcon u_rcon (
        .r  (r),
        .rc (rc)
    );

    assign t  = sub ^ rc;
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign nk = {n0, n1, n2, n3};

endmodule

// File: rtl/rcon.sv
// AES round-constant table; index 0 gives 01000000, indices above 9 give 0.
module rcon
    import aes_pkg::*;
(
    input  logic [3:0] r,
    output word_t      rc
);

    always_comb begin
        rc = '0;
        case (r)
            4'd0: rc = 32'h0100_0000;
            4'd1: rc = 32'h0200_0000;
            4'd2: rc = 32'h0400_0000;
            4'd3: rc = 32'h0800_0000;
            4'd4: rc = 32'h1000_0000;
            4'd5: rc = 32'h2000_0000;
            4'd6: rc = 32'h4000_0000;
            4'd7: rc = 32'h8000_0000;
            4'd8: rc = 32'h1b00_0000;
            4'd9: rc = 32'h3600_0000;
            default: rc = '0;
        endcase
    end

endmodule

// File: rtl/key_sched_ctrl.sv
// AES-128 key-schedule sequencer streaming round keys 0..10 over valid/ready.
// KS_CACHE_EN adds an 11-entry round-key cache with combinational readout.
module key_sched_ctrl
    import aes_pkg::*;
(
    input logic            clk,
    input logic            rst,
    key_sched_ctrl_if.slave bus
);

    ks_state_t  state_q, state_d;
    block_t     key_q, key_d;
    logic [3:0] idx_q, idx_d;
    block_t     next_key;
    logic       xfer;
    logic       last;

    // Abort wins over a simultaneous handshake, so it never counts as a transfer.
    assign xfer = (state_q == StEmit) && bus.rk_ready && !bus.abort;
    assign last = (idx_q == 4'(NumRounds));

    key_round_step u_step (
        .k  (key_q),
        .r  (idx_q),
        .nk (next_key)
    );

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    key_d   = bus.key;
                    idx_d   = '0;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (xfer) begin
                    if (last) begin
                        state_d = StDone;
                    end else begin
                        key_d = next_key;
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            key_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.rk_valid = (state_q == StEmit);
    assign bus.rk       = key_q;
    assign bus.rk_idx   = idx_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = (state_q == StDone);

`ifdef KS_CACHE_EN
    block_t cache_q [NumRounds + 1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= int'(NumRounds); i++) cache_q[i] <= '0;
        end else if (xfer) begin
            cache_q[idx_q] <= key_q;
        end
    end

    always_comb begin
        bus.rd_key = '0;
        if (bus.rd_idx <= 4'(NumRounds)) bus.rd_key = cache_q[bus.rd_idx];
    end
`endif

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Scoreboard bench for key_sched_ctrl using the FIPS-197 AES-128 key vector.
module tb_key_sched_ctrl;
    import aes_pkg::*;

    typedef struct packed {
        logic [3:0] idx;
        block_t     key;
    } exp_t;

    logic clk;
    logic rst;
    key_sched_ctrl_if bus ();

    key_sched_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_errors = 0;
    exp_t   exp_q[$];
    block_t std_rk [11];
    block_t zero_rk [3];
    block_t std_key;
    logic   stall_q = 1'b0;
    block_t held_rk;
    logic [3:0] held_idx;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_std();
        for (int i = 0; i < 11; i++) exp_q.push_back({4'(i), std_rk[i]});
    endtask

    task automatic start_run(input block_t k);
        bus.key   = k;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_idx(input int target);
        int n = 0;
        while (!(bus.rk_valid && bus.rk_idx == 4'(target)) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) check_eq("wait_idx_timeout", 0, 1);
    endtask

    task automatic run_to_done(input bit rnd);
        int n = 0;
        while (!bus.done && n < 400) begin
            if (rnd) bus.rk_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        check_eq("done_seen", bus.done, 1);
        check_eq("done_no_valid", bus.rk_valid, 0);
        step();
        check_eq("idle_after_done", bus.busy, 0);
        check_eq("scoreboard_drained", exp_q.size(), 0);
    endtask

    // Consumer side: pop one expected key per accepted transfer; held keys must not move.
    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q && bus.rk_valid) begin
                check_eq("stall_hold_rk", bus.rk, held_rk);
                check_eq("stall_hold_idx", bus.rk_idx, held_idx);
            end
            if (bus.rk_valid && bus.rk_ready && !bus.abort) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_rk", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("rk_idx", bus.rk_idx, e.idx);
                    check_eq("rk", bus.rk, e.key);
                end
            end
            stall_q  = bus.rk_valid && !bus.rk_ready;
            held_rk  = bus.rk;
            held_idx = bus.rk_idx;
        end
    end

    initial begin
        int done_cyc;
        std_key    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        std_rk[0]  = std_key;
        std_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        std_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        std_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        std_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        std_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        std_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        std_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        std_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        std_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        std_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        zero_rk[0] = '0;
        zero_rk[1] = 128'h62636363626363636263636362636363;
        zero_rk[2] = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.key      = '0;
        bus.abort    = 1'b0;
        bus.rk_ready = 1'b0;
`ifdef KS_CACHE_EN
        bus.rd_idx   = '0;
`endif
        step();
        step();
        check_eq("rst_valid", bus.rk_valid, 0);
        check_eq("rst_rk", bus.rk, 0);
        check_eq("rst_idx", bus.rk_idx, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        rst = 1'b0;
        step();

        // Standard vector, ready held high: keys on 11 consecutive cycles, done in cycle 12.
        push_std();
        bus.rk_ready = 1'b1;
        start_run(std_key);
        check_eq("start_valid", bus.rk_valid, 1);
        check_eq("start_idx", bus.rk_idx, 0);
        check_eq("start_busy", bus.busy, 1);
        done_cyc = 0;
        for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
            step();
            if (bus.done) done_cyc = c;
        end
        check_eq("done_cycle", done_cyc, 11);
        check_eq("done_no_valid", bus.rk_valid, 0);
        check_eq("done_busy", bus.busy, 1);
        step();
        check_eq("done_one_cycle", bus.done, 0);
        check_eq("busy_fall", bus.busy, 0);
        check_eq("std_drained", exp_q.size(), 0);
`ifdef KS_CACHE_EN
        bus.rd_idx = 4'd0;  #1 check_eq("cache_0", bus.rd_key, std_key);
        bus.rd_idx = 4'd1;  #1 check_eq("cache_1", bus.rd_key, std_rk[1]);
        bus.rd_idx = 4'd10; #1 check_eq("cache_10", bus.rd_key, std_rk[10]);
        bus.rd_idx = 4'd15; #1 check_eq("cache_15", bus.rd_key, 0);
`endif

        // Random backpressure.
        push_std();
        start_run(std_key);
        run_to_done(1'b1);

        // A second start with another key mid-run must be ignored.
        push_std();
        bus.rk_ready = 1'b1;
        start_run(std_key);
        wait_idx(4);
        bus.key   = 128'h00112233445566778899aabbccddeeff;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        run_to_done(1'b0);

        // Abort at idx 6 coincident with a handshake: no transfer, no done.
        push_std();
        bus.rk_ready = 1'b1;
        start_run(std_key);
        wait_idx(6);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check_eq("abort_valid", bus.rk_valid, 0);
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_done", bus.done, 0);
        check_eq("abort_left", exp_q.size(), 5);
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("abort_no_done", bus.done, 0);
        end
        exp_q.delete();

        // Restart after abort with the all-zero key; abort again while stalled at idx 3.
        for (int i = 0; i < 3; i++) exp_q.push_back({4'(i), zero_rk[i]});
        start_run('0);
        check_eq("restart_idx", bus.rk_idx, 0);
        wait_idx(3);
        bus.rk_ready = 1'b0;
        bus.abort    = 1'b1;
        step();
        bus.abort = 1'b0;
        check_eq("restart_drained", exp_q.size(), 0);
        check_eq("restart_abort_busy", bus.busy, 0);

        // Asynchronous reset between edges at idx 3.
        push_std();
        bus.rk_ready = 1'b1;
        start_run(std_key);
        wait_idx(3);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_valid", bus.rk_valid, 0);
        check_eq("arst_rk", bus.rk, 0);
        check_eq("arst_idx", bus.rk_idx, 0);
        check_eq("arst_busy", bus.busy, 0);
        check_eq("arst_done", bus.done, 0);
`ifdef KS_CACHE_EN
        bus.rd_idx = 4'd1; #1 check_eq("arst_cache", bus.rd_key, 0);
`endif
        exp_q.delete();
        step();
        rst = 1'b0;
        step();

        // Abort in IDLE alongside start must not block the start.
        push_std();
        bus.abort = 1'b1;
        start_run(std_key);
        bus.abort = 1'b0;
        check_eq("idle_abort_start", bus.rk_valid, 1);
        run_to_done(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_sched_ctrl.md
# key_sched_ctrl

Sequencer for AES-128 key expansion. It accepts a 128-bit cipher key and steps the round counter 0..10. For each step it derives the next round key from the previous one using RotWord, SubWord and the round constant from the `rcon` table. Round keys 0..10 are streamed to the cipher datapath over a valid/ready handshake, one key per accepted transfer.

## Interface
- No parameters; the key size is fixed at 128 bits and the round count at 10.
- clk  input  1  — single clock; all state updates on the rising edge.
- rst  input  1  — asynchronous, active-high reset.
- start  input  1  — begin an expansion; sampled only in IDLE.
- key  input  128  — cipher key; captured on the cycle `start` is accepted.
- abort  input  1  — synchronous cancel of an expansion in progress.
- rk_ready  input  1  — consumer can accept a round key.
- rk_valid  output  1  — `rk` and `rk_idx` are valid.
- rk  output  128  — round key, word 0 in bits [127:96].
- rk_idx  output  4  — round index of `rk`, range 0..10.
- busy  output  1  — high in any state other than IDLE.
- done  output  1  — one-cycle pulse after round key 10 is accepted.

## Operation
- FSM states are IDLE, EMIT and DONE.
- IDLE:
  - When `start` is high, capture `key` into the key register, clear the index to 0 and go to EMIT.
  - `start` is ignored in every other state.
- EMIT:
  - `rk_valid` is 1, `rk` shows the key register and `rk_idx` shows the index.
  - A transfer happens when `rk_valid && rk_ready`.
  - On a transfer with index < 10: the key register loads `next_key(rk, index)`, the index increments and the FSM stays in EMIT.
  - On a transfer with index = 10: go to DONE.
- next_key(k, r):
  - Let w0..w3 be the words of k.
  - t = SubWord(RotWord(w3)) ^ Rcon[r], where `rcon` is indexed with r (index 0 gives 01000000).
  - The new words are w0' = w0 ^ t, w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'.
  - All operations are XOR on 32-bit words; there is no carry.
- DONE: `done` = 1 and `rk_valid` = 0 for exactly one cycle, then go to IDLE.
- abort:
  - In EMIT or DONE, `abort` forces IDLE on the next edge; `done` is not pulsed.
  - `abort` has priority over a simultaneous transfer.
  - `abort` in IDLE has no effect, and `start` is not blocked by it.
- rk_ready low: `rk`, `rk_idx` and `rk_valid` hold stable with no bubble and no advance. Ready may stall for an unbounded time.

## Timing
- Reset values: state IDLE; `rk_valid` 0, `rk` 0, `rk_idx` 0, `busy` 0, `done` 0.
  - Reset mid-expansion returns to IDLE immediately (asynchronous); the partial key is discarded.
- `start` accepted at edge N gives `rk_valid` = 1 with `rk_idx` = 0 and `rk` = `key` after edge N.
- With `rk_ready` held high, the 11 keys appear on 11 consecutive cycles.
- `done` is asserted in the cycle after the round-10 transfer; `busy` falls one cycle after that.
- The minimum start-to-start interval is 13 cycles.
- `rk` is registered, so there is no combinational path from `rk_ready` to `rk`.
- The next-key logic (S-box plus XOR chain) is a single cycle between registers.

## Configuration
- Macro: KS_CACHE_EN.
- Defined:
  - Each transferred round key is also written into an 11×128 register array at its `rk_idx`.
  - Added ports: `rd_idx` (input, 4 bits) and `rd_key` (output, 128 bits, combinational read of the array). These give random-access readout in decryption order.
  - `rd_idx` > 10 reads 0.
  - The array is cleared by `rst`. It is not cleared by `abort` or `start`; entries are simply overwritten on the next run.
- Undefined: the array and the extra ports are absent; the block streams keys only.

## Structure
- Shared package `aes_pkg` holds:
  - the constant for the number of rounds (10);
  - the state enumeration type for IDLE, EMIT and DONE;
  - the 32-bit word and 128-bit block typedefs.
- Sub-module `key_round_step` is combinational. It takes k[127:0] and r[3:0] and returns the next key.
  - It instantiates `rcon` and four byte S-boxes.
- The FSM, counter, handshake and optional cache live in `key_sched_ctrl`.

## Test plan
- Standard key vector: key 2b7e151628aed2a6abf7158809cf4f3c with ready held high.
  - Expected idx0 = key, idx1 = a0fafe1788542cb123a339392a6c7605, idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `done` pulses in cycle 12.
- Backpressure: ready toggles on a random pattern.
  - Each key is held stable while stalled; the same 11 keys appear in order with no duplicates or skips.
- Start ignored while busy: `start` is pulsed with a different key at idx 4.
  - The sequence is unaffected and equals the standard key vector stream.
- Abort: abort at idx 6 at the same time as a transfer.
  - Expected: IDLE next cycle, `rk_valid` 0, no `done`.
  - A new start then begins at idx 0.
- Async reset mid-run: `rst` asserted at idx 3 between clock edges.
  - All outputs go to 0 immediately; `busy` is 0.
- KS_CACHE_EN: after the standard key vector run, `rd_idx` = 1 gives a0fafe17…7605, `rd_idx` = 10 gives d014f9a8…0ca6 and `rd_idx` = 15 gives 0.
